data_mux_slot_scheduler: RTL

//  Time-slot scheduler for the data multiplexer. It divides each symbol period
//  of SYMBOL_CYCLES clk cycles into `mode` equal slots of `switch_clk_cycles`

---
 rtl/data_mux_slot_scheduler_if.sv | 34 +++
 rtl/data_mux_slot_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_mux_slot_scheduler_if.sv
// Purpose     : handshake/bus bundle between the stream sources, the slot scheduler and the mux sink.
// Latency     : none (wires only).
// Backpressure: ds_ready tells each source when its slot is open; there is no stall toward the sink.
interface data_mux_slot_scheduler_if #(
   parameter int DATA_W = 8
);
   // configuration / control
   logic              enable;
   logic [1:0]        mode;
   logic [2:0]        switch_clk_cycles;
   // stream side
   logic [DATA_W-1:0] ds1;
   logic [DATA_W-1:0] ds2;
   logic [DATA_W-1:0] ds3;
   logic [2:0]        ds_valid;
   logic [2:0]        ds_ready;
   // mux output side
   logic [DATA_W-1:0] mux_data;
   logic              mux_valid;
   logic [1:0]        sel;
   logic              symbol_start;
   logic              cfg_err;
   logic              underrun;

   modport master (
      output enable, mode, switch_clk_cycles, ds1, ds2, ds3, ds_valid,
      input  ds_ready, mux_data, mux_valid, sel, symbol_start, cfg_err, underrun
   );

   modport slave (
      input  enable, mode, switch_clk_cycles, ds1, ds2, ds3, ds_valid,
      output ds_ready, mux_data, mux_valid, sel, symbol_start, cfg_err, underrun
   );
endinterface

// File: rtl/data_mux_slot_scheduler.sv
// Purpose     : time-slot scheduler granting the shared mux output to DS1..DS3 in slot order per symbol.
// Latency     : 1 clk from a RUN cycle (slot owner sampled) to mux_data/mux_valid/sel/symbol_start.
// Backpressure: none upstream; an owner without valid in its slot loses that sample (underrun pulse).
module data_mux_slot_scheduler #(
   parameter int DATA_W        = 8,
   parameter int SYMBOL_CYCLES = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   data_mux_slot_scheduler_if.slave  sched_io
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [2:0] CYC_LAST = 3'(SYMBOL_CYCLES - 1);
   localparam logic [4:0] SYM5     = 5'(SYMBOL_CYCLES);

   // sequencing state
   state_t            state_q;
   logic [2:0]        cyc_q;
   logic [2:0]        cyc_d;
   logic [1:0]        slot_q;
   logic [1:0]        slot_d;
   logic [2:0]        in_slot_q;
   logic [2:0]        in_slot_d;

   // configuration latched at the last accepted boundary
   logic [1:0]        mode_l_q;
   logic [2:0]        swc_l_q;

   // registered outputs
   logic [DATA_W-1:0] mux_data_q;
   logic              mux_valid_q;
   logic [1:0]        sel_q;
   logic              symbol_start_q;
   logic              cfg_err_q;
   logic              underrun_q;

   // combinational helpers
   logic [4:0]        slot_prod;
   logic              cfg_legal;
   logic              boundary;
   logic              slot_live;
   logic              owner_vld;
   logic [DATA_W-1:0] owner_dat;

   // Config check: slots must tile the symbol exactly; 5 bits hold 3*7 without wrap.
   always_comb begin
      slot_prod = {3'b000, sched_io.mode} * {2'b00, sched_io.switch_clk_cycles};
      cfg_legal = (sched_io.mode != 2'd0) && (slot_prod == SYM5);
   end

   // Boundary: every cycle outside RUN, otherwise only on the last cycle of the symbol.
   always_comb begin
      boundary = (state_q != ST_RUN) || (cyc_q == CYC_LAST);
   end

   // Next values of the RUN counters when no boundary occurs; slot advances on in_slot wrap.
   always_comb begin
      cyc_d     = cyc_q + 3'd1;
      in_slot_d = in_slot_q + 3'd1;
      slot_d    = slot_q;
      if (in_slot_q == (swc_l_q - 3'd1)) begin
         in_slot_d = 3'd0;
         slot_d    = slot_q + 2'd1;
      end
   end

   // Slot owner data/valid select; slot 3 cannot occur under a legal config.
   always_comb begin
      owner_vld = 1'b0;
      owner_dat = sched_io.ds1;
      case (slot_q)
         2'd0: begin
            owner_vld = sched_io.ds_valid[0];
            owner_dat = sched_io.ds1;
         end
         2'd1: begin
            owner_vld = sched_io.ds_valid[1];
            owner_dat = sched_io.ds2;
         end
         2'd2: begin
            owner_vld = sched_io.ds_valid[2];
            owner_dat = sched_io.ds3;
         end
         default: begin
            owner_vld = 1'b0;
            owner_dat = sched_io.ds1;
         end
      endcase
   end

   // Grant: one-hot ready for the current slot owner while running. The mode_l
   // term is defensive only; a legal config never lets slot reach mode_l.
   always_comb begin
      slot_live = (state_q == ST_RUN) && (slot_q < mode_l_q);
      sched_io.ds_ready[0] = slot_live && (slot_q == 2'd0);
      sched_io.ds_ready[1] = slot_live && (slot_q == 2'd1);
      sched_io.ds_ready[2] = slot_live && (slot_q == 2'd2);
   end

   // FSM, counters, config latch and registered output stage in one process.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cyc_q          <= 3'd0;
         slot_q         <= 2'd0;
         in_slot_q      <= 3'd0;
         mode_l_q       <= 2'd0;
         swc_l_q        <= 3'd0;
         mux_data_q     <= '0;
         mux_valid_q    <= 1'b0;
         sel_q          <= 2'd0;
         symbol_start_q <= 1'b0;
         cfg_err_q      <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         // Output stage reflects the cycle just finished.
         if (state_q == ST_RUN) begin
            sel_q          <= slot_q;
            symbol_start_q <= (cyc_q == 3'd0);
            if (owner_vld) begin
               mux_data_q  <= owner_dat;
               mux_valid_q <= 1'b1;
               underrun_q  <= 1'b0;
            end else begin
               mux_valid_q <= 1'b0;
               underrun_q  <= 1'b1;
            end
         end else begin
            mux_valid_q    <= 1'b0;
            symbol_start_q <= 1'b0;
            underrun_q     <= 1'b0;
         end

         // Sequencing: decisions only at boundaries so a started symbol always completes.
         if (boundary) begin
            cyc_q     <= 3'd0;
            slot_q    <= 2'd0;
            in_slot_q <= 3'd0;
            if (!sched_io.enable) begin
               state_q <= ST_IDLE;
            end else if (cfg_legal) begin
               state_q   <= ST_RUN;
               mode_l_q  <= sched_io.mode;
               swc_l_q   <= sched_io.switch_clk_cycles;
               cfg_err_q <= 1'b0;
            end else begin
               state_q   <= ST_HOLD;
               cfg_err_q <= 1'b1;
            end
         end else begin
            cyc_q     <= cyc_d;
            slot_q    <= slot_d;
            in_slot_q <= in_slot_d;
         end
      end
   end

   assign sched_io.mux_data     = mux_data_q;
   assign sched_io.mux_valid    = mux_valid_q;
   assign sched_io.sel          = sel_q;
   assign sched_io.symbol_start = symbol_start_q;
   assign sched_io.cfg_err      = cfg_err_q;
   assign sched_io.underrun     = underrun_q;

endmodule
